vga_rect_sequencer: RTL and testbench

Frame-synchronous controller for the rectangle overlay datapath of the VGA card. Two independent requesters (e.g. a UART command decoder and an animation engine) write rectangle descriptors through valid/ready ports. A round-robin arbiter puts these writes into a shadow register file, and the block commits them to the live set only at frame end, so no frame is ever drawn with a half-updated scene. The block sits between the sync generator (x/y, strobe, blank, frame-end) and the top-level single-bit R/G/B outputs, and drives those outputs from the live set.

---
 rtl/vga_rect_sequencer.sv | 160 ++++++++++++++++
 tb/tb_vga_rect_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_sequencer.sv
// Rectangle overlay sequencer: arbitrates two descriptor writers into a shadow set, commits it to the live set at frame end, and renders pixels from the live set.
// Latency: pixel colour is registered 1 cycle after i_pix_stb; a commit takes N_RECT cycles after the frame_end edge.
// Backpressure: both ready outputs are 0 during COMMIT; in RUN one valid requester per cycle is granted, round-robin when both are valid.
module vga_rect_sequencer #(
    parameter int N_RECT = 4,
    localparam int IDX_W  = (N_RECT > 1) ? $clog2(N_RECT) : 1,
    localparam int RECT_W = 41
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_stb,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic              i_blank,
    input  logic              i_frame_end,
    input  logic              i_a_valid,
    input  logic [IDX_W-1:0]  i_a_idx,
    input  logic [RECT_W-1:0] i_a_data,
    input  logic              i_b_valid,
    input  logic [IDX_W-1:0]  i_b_idx,
    input  logic [RECT_W-1:0] i_b_data,
    output logic              o_a_ready,
    output logic              o_b_ready,
    output logic              o_busy,
    output logic              o_commit_done,
    output logic              o_r,
    output logic              o_g,
    output logic              o_b
);

    typedef struct packed {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
        logic [2:0] rgb;
    } rect_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RECT - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                prefer_b_q, prefer_b_d;
    rect_t               shadow_q [N_RECT];
    rect_t               shadow_d [N_RECT];
    rect_t               live_q   [N_RECT];
    rect_t               live_d   [N_RECT];
    logic [N_RECT-1:0]   dirty_q, dirty_d;
    logic [2:0]          rgb_q, rgb_d;
    logic [2:0]          hit_rgb;
    logic                run;
    logic                a_fire;
    logic                b_fire;

    assign run           = (state_q == ST_RUN);
    assign a_fire        = i_a_valid & o_a_ready;
    assign b_fire        = i_b_valid & o_b_ready;
    assign o_busy        = (state_q == ST_COMMIT);
    assign o_commit_done = (state_q == ST_COMMIT) && (cnt_q == LAST_IDX);
    assign o_r           = rgb_q[2];
    assign o_g           = rgb_q[1];
    assign o_b           = rgb_q[0];

    // Grant: a lone valid requester wins; on contention the one not granted last time wins.
    always_comb begin
        o_a_ready = 1'b0;
        o_b_ready = 1'b0;
        if (run) begin
            if (i_a_valid && (!i_b_valid || !prefer_b_q)) begin
                o_a_ready = 1'b1;
            end else if (i_b_valid) begin
                o_b_ready = 1'b1;
            end
        end
    end

    // Shadow writes, round-robin pointer, and the RUN/COMMIT sequencer that copies dirty entries to live.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prefer_b_d = prefer_b_q;
        shadow_d   = shadow_q;
        live_d     = live_q;
        dirty_d    = dirty_q;

        if (a_fire) begin
            shadow_d[i_a_idx] = rect_t'(i_a_data);
            dirty_d[i_a_idx]  = 1'b1;
            prefer_b_d        = 1'b1;
        end else if (b_fire) begin
            shadow_d[i_b_idx] = rect_t'(i_b_data);
            dirty_d[i_b_idx]  = 1'b1;
            prefer_b_d        = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                // dirty_d includes a write landing on the same edge as frame_end
                if (i_frame_end && (|dirty_d)) begin
                    state_d = ST_COMMIT;
                    cnt_d   = '0;
                end
            end
            ST_COMMIT: begin
                if (dirty_q[cnt_q]) begin
                    live_d[cnt_q]  = shadow_q[cnt_q];
                    dirty_d[cnt_q] = 1'b0;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Hit test over the live set; iterating downward lets the lowest index win.
    always_comb begin
        hit_rgb = 3'b000;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if ((i_x > live_q[i].x0) && (i_x < live_q[i].x1) &&
                (i_y > live_q[i].y0) && (i_y < live_q[i].y1)) begin
                hit_rgb = live_q[i].rgb;
            end
        end
        rgb_d = rgb_q;
        if (i_pix_stb) begin
            rgb_d = i_blank ? 3'b000 : hit_rgb;
        end
    end

    // State registers; reset also discards any partially committed live set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            prefer_b_q <= 1'b0;
            shadow_q   <= '{default: '0};
            live_q     <= '{default: '0};
            dirty_q    <= '0;
            rgb_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prefer_b_q <= prefer_b_d;
            shadow_q   <= shadow_d;
            live_q     <= live_d;
            dirty_q    <= dirty_d;
            rgb_q      <= rgb_d;
        end
    end

endmodule

// File: tb/tb_vga_rect_sequencer.sv
module tb_vga_rect_sequencer;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_stb;
    logic [9:0]    x;
    logic [8:0]    y;
    logic          blank;
    logic          frame_end;
    logic          a_valid, b_valid;
    logic [IW-1:0] a_idx, b_idx;
    logic [40:0]   a_data, b_data;
    logic          a_ready, b_ready, busy, commit_done, o_r, o_g, o_b;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [40:0] shadow_m [N];
    logic [40:0] live_m   [N];
    bit          dirty_m  [N];
    bit          prefer_a;

    vga_rect_sequencer #(.N_RECT(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(pix_stb), .i_x(x), .i_y(y),
        .i_blank(blank), .i_frame_end(frame_end),
        .i_a_valid(a_valid), .i_a_idx(a_idx), .i_a_data(a_data),
        .i_b_valid(b_valid), .i_b_idx(b_idx), .i_b_data(b_data),
        .o_a_ready(a_ready), .o_b_ready(b_ready), .o_busy(busy),
        .o_commit_done(commit_done), .o_r(o_r), .o_g(o_g), .o_b(o_b)
    );

    always #5 clk = ~clk;

    function automatic logic [40:0] mk(int x0, int y0, int x1, int y1, int rgb);
        return {10'(x0), 9'(y0), 10'(x1), 9'(y1), 3'(rgb)};
    endfunction

    // colour the spec's hit rules give for a point against the reference live set
    function automatic logic [2:0] ref_pix(int px, int py, bit bl);
        logic [40:0] r;
        if (bl) return 3'b000;
        for (int i = 0; i < N; i++) begin
            r = live_m[i];
            if (int'(r[40:31]) < px && px < int'(r[21:12]) &&
                int'(r[30:22]) < py && py < int'(r[11:3]))
                return r[2:0];
        end
        return 3'b000;
    endfunction

    function automatic bit any_dirty();
        for (int i = 0; i < N; i++) if (dirty_m[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            shadow_m[i] = '0;
            live_m[i]   = '0;
            dirty_m[i]  = 1'b0;
        end
        prefer_a = 1'b1;
    endtask

    task automatic model_write(bit is_b, int idx, logic [40:0] d);
        shadow_m[idx] = d;
        dirty_m[idx]  = 1'b1;
        prefer_a      = is_b;
    endtask

    task automatic model_commit();
        for (int i = 0; i < N; i++) begin
            if (dirty_m[i]) live_m[i] = shadow_m[i];
            dirty_m[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(bit is_b, int idx, logic [40:0] d);
        int waited = 0;
        bit rdy;
        if (is_b) begin b_valid = 1'b1; b_idx = IW'(idx); b_data = d; end
        else      begin a_valid = 1'b1; a_idx = IW'(idx); a_data = d; end
        forever begin
            @(negedge clk);
            rdy = is_b ? b_ready : a_ready;
            if (rdy) break;
            waited++;
            if (waited > 20) break;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL write_grant: %s never ready (got 0, need 1)", is_b ? "B" : "A");
            a_valid = 1'b0; b_valid = 1'b0;
            tick();
            return;
        end
        tick();
        model_write(is_b, idx, d);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic pixel(int px, int py, bit bl, string name);
        logic [2:0] exp;
        pix_stb = 1'b1; x = 10'(px); y = 9'(py); blank = bl;
        tick();
        pix_stb = 1'b0;
        exp = ref_pix(px, py, bl);
        checks++;
        if ({o_r, o_g, o_b} !== exp) begin
            errors++;
            $display("FAIL %s: pixel (%0d,%0d) blank=%0d got %b need %b", name, px, py, bl, {o_r, o_g, o_b}, exp);
        end
    endtask

    task automatic do_frame_end(string name);
        bit exp_commit;
        int busy_cnt = 0, done_cnt = 0, done_at = -1;
        exp_commit = any_dirty();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (commit_done) begin done_cnt++; done_at = c; end
        end
        tick();
        checks++;
        if (busy_cnt != (exp_commit ? N : 0)) begin
            errors++;
            $display("FAIL %s_busy: busy cycles got %0d need %0d", name, busy_cnt, exp_commit ? N : 0);
        end
        checks++;
        if (done_cnt != (exp_commit ? 1 : 0) || (exp_commit && done_at != N - 1)) begin
            errors++;
            $display("FAIL %s_done: commit_done pulses got %0d at %0d need %0d at %0d",
                     name, done_cnt, done_at, exp_commit ? 1 : 0, N - 1);
        end
        if (exp_commit) model_commit();
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_stb = 0; x = 0; y = 0; blank = 0; frame_end = 0;
        a_valid = 0; b_valid = 0; a_idx = 0; b_idx = 0; a_data = 0; b_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, commit_done, o_r, o_g, o_b, a_ready, b_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b need 0000000", {busy, commit_done, o_r, o_g, o_b, a_ready, b_ready});
        end
        rst = 1'b0;
        tick();
        pixel(200, 100, 1'b0, "reset_live_empty");
    endtask

    task automatic test_basic();
        do_write(1'b0, 0, mk(120, 40, 280, 200, 3'b010));
        pixel(200, 100, 1'b0, "basic_before_commit");
        do_frame_end("basic_commit");
        pixel(200, 100, 1'b0, "basic_inside");
        pixel(120, 100, 1'b0, "basic_left_edge");
        pixel(121, 41, 1'b0, "basic_corner_in");
        pixel(280, 100, 1'b0, "basic_right_edge");
    endtask

    task automatic test_arbiter();
        bit exp_a;
        a_valid = 1; a_idx = 1; a_data = mk(10, 10, 50, 50, 3'b100);
        b_valid = 1; b_idx = 2; b_data = mk(60, 10, 90, 50, 3'b001);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_a = prefer_a;
            checks++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                errors++;
                $display("FAIL arb_alternate: cycle %0d ready a/b got %b%b need %b%b", c, a_ready, b_ready, exp_a, !exp_a);
            end
            tick();
            if (exp_a) model_write(1'b0, 1, a_data);
            else       model_write(1'b1, 2, b_data);
        end
        a_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
                errors++;
                $display("FAIL arb_b_only: cycle %0d ready a/b got %b%b need 01", c, a_ready, b_ready);
            end
            tick();
            model_write(1'b1, 2, b_data);
        end
        b_valid = 0;
        do_frame_end("arb_commit");
        pixel(30, 30, 1'b0, "arb_entry1");
        pixel(70, 30, 1'b0, "arb_entry2");
    endtask

    task automatic test_last_write();
        do_write(1'b0, 1, mk(400, 300, 500, 400, 3'b100));
        do_write(1'b1, 1, mk(400, 300, 500, 400, 3'b010));
        do_write(1'b0, 1, mk(400, 300, 500, 400, 3'b001));
        do_frame_end("lastwr_commit");
        pixel(450, 350, 1'b0, "lastwr_blue");
        pixel(200, 100, 1'b0, "lastwr_entry0_kept");
        pixel(70, 30, 1'b0, "lastwr_entry2_kept");
    endtask

    task automatic test_overlap();
        do_write(1'b0, 0, mk(200, 100, 300, 200, 3'b010));
        do_write(1'b1, 1, mk(220, 120, 320, 220, 3'b100));
        do_frame_end("overlap_commit");
        pixel(250, 150, 1'b0, "overlap_green");
        pixel(250, 150, 1'b1, "overlap_blank");
        pixel(310, 210, 1'b0, "overlap_red_only");
    endtask

    task automatic test_commit_ignore();
        int busy_cnt = 0;
        do_write(1'b1, 3, mk(5, 5, 15, 15, 3'b111));
        frame_end = 1'b1;
        tick();
        a_valid = 1; a_idx = 0; a_data = mk(0, 0, 600, 400, 3'b101);
        b_valid = 1; b_idx = 2; b_data = mk(0, 0, 600, 400, 3'b011);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL commit_blocks: cycle %0d ready a/b busy got %b%b%b need 001", c, a_ready, b_ready, busy);
            end
        end
        tick();
        frame_end = 1'b0; a_valid = 0; b_valid = 0;
        model_commit();
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        tick();
        checks++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL commit_no_second: busy cycles got %0d need 0", busy_cnt);
        end
        pixel(10, 10, 1'b0, "commit_entry3");
        do_frame_end("clean_frame_end");
    endtask

    task automatic test_random();
        int op, idx, x0, y0, x1, y1, px, py, j;
        logic [40:0] r;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                idx = $urandom_range(0, N - 1);
                x0 = $urandom_range(0, 600); y0 = $urandom_range(0, 450);
                x1 = x0 + $urandom_range(0, 120); y1 = y0 + $urandom_range(0, 60);
                if ($urandom_range(0, 7) == 0) begin px = x0; x0 = x1; x1 = px; end
                do_write(op == 1, idx, mk(x0, y0, x1, y1, $urandom_range(0, 7)));
            end else if (op == 2) begin
                do_frame_end("rand_commit");
            end else begin
                for (int k = 0; k < 3; k++) begin
                    j = $urandom_range(0, N - 1);
                    r = live_m[j];
                    if ($urandom_range(0, 1) == 1) begin
                        px = int'(r[40:31]) + $urandom_range(0, 120);
                        py = int'(r[30:22]) + $urandom_range(0, 60);
                    end else begin
                        px = $urandom_range(0, 639);
                        py = $urandom_range(0, 479);
                    end
                    pixel(px % 1024, py % 512, $urandom_range(0, 7) == 0, "rand_pixel");
                end
            end
        end
    endtask

    task automatic test_reset_mid_commit();
        do_write(1'b0, 0, mk(100, 100, 200, 200, 3'b110));
        do_frame_end("rstc_setup");
        pixel(150, 150, 1'b0, "rstc_lit_before");
        do_write(1'b0, 2, mk(300, 300, 400, 400, 3'b011));
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, commit_done, o_r, o_g, o_b} !== 5'b0) begin
            errors++;
            $display("FAIL rstc_outputs: got %b need 00000", {busy, commit_done, o_r, o_g, o_b});
        end
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        pixel(150, 150, 1'b0, "rstc_live_cleared");
        pixel(350, 350, 1'b0, "rstc_entry2_absent");
        a_valid = 1; a_idx = 1; a_data = mk(1, 1, 9, 9, 3'b001);
        b_valid = 1; b_idx = 1; b_data = mk(1, 1, 9, 9, 3'b100);
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstc_grant_a: ready a/b got %b%b need 10", a_ready, b_ready);
        end
        tick();
        a_valid = 0; b_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbiter();
        test_last_write();
        test_overlap();
        test_commit_ignore();
        test_random();
        test_reset_mid_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete (time limit reached)");
        $fatal(1);
    end
endmodule
